// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad reader with sweep-level debounce and one-shot key strobe
// Ports: clock_100Mhz clock; reset async active-low; row[3:0] active-low row inputs;
//        col[3:0] active-low column drive; key_code[3:0] debounced key; key_valid new-key pulse;
//        key_held debounced press level.
module keypad_scanner #(
  parameter int DWELL_CYCLES    = 100000,
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CW = $clog2(DWELL_CYCLES);
  localparam int MW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SWEEPS);
  // nibble {c,r} holds the hex legend of the key at column c, row r
  localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;
  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_e;
  logic [3:0]    row_meta_q, row_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic          acc_seen_q, acc_seen_d, acc_multi_q, acc_multi_d;
  logic [3:0]    acc_code_q, acc_code_d;
  res_e          cand_q, cand_d;
  logic [3:0]    cand_code_q, cand_code_d;
  logic [MW-1:0] match_q, match_d;
  logic [3:0]    code_q, code_d;
  logic          held_q, held_d, valid_q, valid_d;
  logic          sample, sweep_end, hit, hit_multi, same, stable, new_key, drop;
  logic          sw_seen, sw_multi;
  logic [3:0]    low, hit_code, sw_code;
  logic [1:0]    hit_row;
  logic [MW-1:0] match_next;
  res_e          res;
  always_comb begin
    sample     = cnt_q == CNT_LAST;
    sweep_end  = sample && col_idx_q == 2'd3;
    low        = ~row_sync_q;
    hit        = |low;
    // more than one low row bit in this column
    hit_multi  = |(low & (low - 4'd1));
    hit_row    = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    hit_code   = KEY_MAP[{col_idx_q, hit_row, 2'b00} +: 4];
    // running sweep result including the column being sampled now
    sw_seen    = acc_seen_q | hit;
    sw_multi   = acc_multi_q | hit_multi | (acc_seen_q & hit);
    sw_code    = hit ? hit_code : acc_code_q;
    res        = sw_multi ? RES_MULTI : sw_seen ? RES_KEY : RES_NONE;
    same       = res == cand_q && (res != RES_KEY || sw_code == cand_code_q);
    match_next = !same ? MW'(1) : match_q == MATCH_MAX ? match_q : MW'(match_q + 1'b1);
    stable     = match_next == MATCH_MAX;
    new_key    = stable && res == RES_KEY && (!held_q || sw_code != code_q);
    drop       = stable && res == RES_NONE;
  end
  always_comb begin
    cnt_d       = sample ? '0 : CW'(cnt_q + 1'b1);
    col_idx_d   = sample ? col_idx_q + 2'd1 : col_idx_q;
    acc_seen_d  = sweep_end ? 1'b0 : sample ? sw_seen : acc_seen_q;
    acc_multi_d = sweep_end ? 1'b0 : sample ? sw_multi : acc_multi_q;
    acc_code_d  = sweep_end ? 4'd0 : sample ? sw_code : acc_code_q;
    cand_d      = sweep_end ? res : cand_q;
    cand_code_d = sweep_end ? sw_code : cand_code_q;
    match_d     = sweep_end ? match_next : match_q;
    valid_d     = sweep_end && new_key;
    code_d      = (sweep_end && new_key) ? sw_code : code_q;
    held_d      = (sweep_end && new_key) ? 1'b1 : (sweep_end && drop) ? 1'b0 : held_q;
  end
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      acc_seen_q  <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_code_q  <= 4'd0;
      cand_q      <= RES_NONE;
      cand_code_q <= 4'd0;
      match_q     <= '0;
      code_q      <= 4'd0;
      held_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      row_meta_q  <= row;
      row_sync_q  <= row_meta_q;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      acc_seen_q  <= acc_seen_d;
      acc_multi_q <= acc_multi_d;
      acc_code_q  <= acc_code_d;
      cand_q      <= cand_d;
      cand_code_q <= cand_code_d;
      match_q     <= match_d;
      code_q      <= code_d;
      held_q      <= held_d;
      valid_q     <= valid_d;
    end
  end
  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side companion to the multiplexed 7-segment output driver. It is a 4x4 matrix keypad reader for the Pmod KYPD on the Basys 3.
- Drives one column low at a time, samples the four row lines, debounces across whole sweeps, and reports one key code with a single-cycle valid strobe.
- Feeds the game-control logic (cell cursor / run / step commands).

Parameters:
- DWELL_CYCLES, 100000, clock cycles each column is driven before its rows are sampled (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SWEEPS, 4, consecutive identical sweep results required to change the debounced state; minimum 1.

Ports:
- clock_100Mhz  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- row  input  4  keypad row lines, active-low, externally pulled up; asynchronous to the clock.
- col  output  4  keypad column drives, active-low; exactly one bit is 0 at all times.
- key_code  output  4  hex value of the debounced key.
- key_valid  output  1  one-cycle pulse: a new debounced key was accepted.
- key_held  output  1  level: a debounced key is currently pressed.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - col=4'b1110; key_code=0; key_valid=0; key_held=0.
  - Dwell counter=0, column index=0, row synchronizer=4'b1111.
  - Candidate=NONE, match count=0.
- Synchronizer: row passes through a 2-flop synchronizer before any use.
- Scan sequence:
  - Column index c cycles 0→1→2→3→0; col = ~(4'b0001<<c).
  - The dwell counter runs 0..DWELL_CYCLES-1. Sampling happens in the cycle where the counter equals DWELL_CYCLES-1; c advances and the counter clears on the same edge.
  - One sweep = 4*DWELL_CYCLES cycles.
- Per-column sample: any synchronized row bit that is 0 marks key (r,c), where r = row bit index.
- Key map, listed as column c: keys for r=0..3:
  - c0: 1,4,7,0
  - c1: 2,5,8,F
  - c2: 3,6,9,E
  - c3: A,B,C,D
- Sweep result, fixed at the column-3 sample:
  - NONE if no key was seen.
  - KEY(code) if exactly one key was seen in the whole sweep.
  - MULTI if two or more keys were seen, in the same or different columns.
- Debounce, updated on the same edge as the column-3 sample:
  - Result equals candidate: match count increments, saturating at DEBOUNCE_SWEEPS.
  - Result differs from candidate: candidate = result, match count = 1.
  - Stable state changes only when match count reaches DEBOUNCE_SWEEPS. With DEBOUNCE_SWEEPS=1, every sweep updates.
  - MULTI never becomes stable. A MULTI sweep resets the count but leaves key_held and key_code unchanged.
- Outputs on a stable change, registered and visible the cycle after the column-3 sample edge:
  - Stable NONE→KEY(k): key_code=k, key_held=1, key_valid=1 for exactly one cycle.
  - Stable KEY(j)→KEY(k), k≠j, possible without an intervening NONE: key_code=k, key_held stays 1, key_valid pulses.
  - Stable KEY→NONE: key_held=0, key_code retains last value, no pulse.
  - A key held indefinitely produces exactly one key_valid pulse; there is no auto-repeat.
- Reset mid-sweep: everything returns to reset values immediately. Scanning restarts from column 0 after reset deasserts; a held key is re-detected and pulses again.
- No combinational path from row to any output.

Test Plan (DWELL_CYCLES=8, DEBOUNCE_SWEEPS=3, sweep=32 cycles):
- Reset released, no key:
  - col sequence 1110,1101,1011,0111 with 8 cycles each, repeating.
  - key_valid never 1; key_held=0; key_code=0.
- Hold row[2] low only while col=1011 (key 9) from t=0:
  - Exactly one key_valid pulse, one cycle after the 3rd sweep end.
  - key_code=4'h9, key_held=1 thereafter.
- Release key 9:
  - key_held falls one cycle after the 3rd consecutive NONE sweep end.
  - key_code stays 9; no pulse.
- Bounce test: key 5 (c1,r1) toggling every sweep for 4 sweeps, then steady:
  - No pulse during bouncing.
  - Single pulse with key_code=5 after 3 steady sweeps.
- Keys 1 and D both pressed: no key_valid, key_held stays 0. Release D, keeping 1 pressed: pulse with key_code=1 after 3 sweeps.
- Key A held; assert reset=0 for 5 cycles mid-sweep:
  - During reset: outputs go to reset values, col=1110.
  - After release: key_valid pulses again with key_code=A, 3 full sweeps later.
